// File: rtl/snake_dir_arb.sv
// Direction arbiter for the snake game: merges UART and board-key turn requests,
// filters reversals and buffers up to two turns that are applied on each move tick.
module snake_dir_arb #(
  parameter logic [1:0] INIT_DIR = 2'b11
) (
  input  logic       lcd_pclk,
  input  logic       rst_n,
  input  logic       uart_up,
  input  logic       uart_down,
  input  logic       uart_left,
  input  logic       uart_right,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       move_tick,
  input  logic       game_over,
  input  logic       restart,
  output logic [1:0] dir,
  output logic       run_en,
  output logic       dir_chg,
  output logic       drop
);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  state_t     state;
  logic       last_b;
  logic [1:0] fifo0;
  logic [1:0] fifo1;
  logic [1:0] cnt;

  logic [3:0] u_vec;
  logic [3:0] b_vec;
  logic       u_valid;
  logic       b_valid;
  logic       grant;
  logic       tie;
  logic       pick_u;
  logic [1:0] gdir;
  logic [1:0] ref_dir;
  logic       reject;
  logic       pop;
  logic       push;
  logic       full_drop;
  logic [1:0] nf0;
  logic [1:0] nf1;
  logic [1:0] ncnt;

  function automatic logic [1:0] enc(input logic [3:0] v);
    case (v)
      4'b1000: enc = 2'b00;
      4'b0100: enc = 2'b01;
      4'b0010: enc = 2'b10;
      default: enc = 2'b11;
    endcase
  endfunction

  assign u_vec   = {uart_up, uart_down, uart_left, uart_right};
  assign b_vec   = {btn_up, btn_down, btn_left, btn_right};
  assign u_valid = $onehot(u_vec);
  assign b_valid = $onehot(b_vec);
  assign grant   = u_valid | b_valid;
  assign tie     = u_valid & b_valid;
  // last_b set means B won the previous grant, so U gets the next tie
  assign pick_u  = u_valid & (~b_valid | last_b);
  assign gdir    = pick_u ? enc(u_vec) : enc(b_vec);

  // Turns are checked against the last queued turn, not the current heading
  assign ref_dir   = (cnt == 2'd2) ? fifo1 : (cnt == 2'd1) ? fifo0 : dir;
  assign reject    = (gdir == ref_dir) || (gdir == {ref_dir[1], ~ref_dir[0]});
  assign pop       = move_tick && (cnt != 2'd0);
  assign push      = grant && !reject && ((cnt != 2'd2) || pop);
  assign full_drop = grant && !reject && (cnt == 2'd2) && !pop;

  always_comb begin
    nf0  = fifo0;
    nf1  = fifo1;
    ncnt = cnt;
    if (pop) begin
      nf0  = fifo1;
      ncnt = cnt - 2'd1;
    end
    if (push) begin
      if (ncnt == 2'd0) nf0 = gdir;
      else              nf1 = gdir;
      ncnt = ncnt + 2'd1;
    end
  end

  always_ff @(posedge lcd_pclk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      dir     <= INIT_DIR;
      run_en  <= 1'b0;
      dir_chg <= 1'b0;
      drop    <= 1'b0;
      last_b  <= 1'b1;
      fifo0   <= 2'b00;
      fifo1   <= 2'b00;
      cnt     <= 2'd0;
    end else begin
      dir_chg <= 1'b0;
      drop    <= 1'b0;
      if (restart) begin
        state  <= IDLE;
        dir    <= INIT_DIR;
        run_en <= 1'b0;
        last_b <= 1'b1;
        cnt    <= 2'd0;
      end else begin
        case (state)
          IDLE: begin
            if (grant) begin
              dir     <= gdir;
              dir_chg <= 1'b1;
              drop    <= tie;
              last_b  <= ~pick_u;
              state   <= RUN;
              run_en  <= 1'b1;
            end
          end
          RUN: begin
            if (game_over) begin
              state  <= HALT;
              run_en <= 1'b0;
              cnt    <= 2'd0;
            end else begin
              if (grant) last_b <= ~pick_u;
              drop  <= tie | (grant & reject) | full_drop;
              if (pop) begin
                dir     <= fifo0;
                dir_chg <= 1'b1;
              end
              fifo0 <= nf0;
              fifo1 <= nf1;
              cnt   <= ncnt;
            end
          end
          HALT: begin
            run_en <= 1'b0;
          end
          default: begin
            state  <= IDLE;
            run_en <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_snake_dir_arb.sv
// Directed bench for snake_dir_arb: each driven cycle queues the expected
// {dir, run_en, dir_chg, drop}; a monitor checks them one cycle later.
module tb_snake_dir_arb;

  logic       lcd_pclk;
  logic       rst_n;
  logic       uart_up, uart_down, uart_left, uart_right;
  logic       btn_up, btn_down, btn_left, btn_right;
  logic       move_tick, game_over, restart;
  logic [1:0] dir;
  logic       run_en, dir_chg, drop;

  logic [4:0] exp_q[$];
  string      name_q[$];
  int         n_tests;
  int         n_fail;

  snake_dir_arb #(.INIT_DIR(2'b11)) dut (
    .lcd_pclk  (lcd_pclk),
    .rst_n     (rst_n),
    .uart_up   (uart_up),
    .uart_down (uart_down),
    .uart_left (uart_left),
    .uart_right(uart_right),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .btn_left  (btn_left),
    .btn_right (btn_right),
    .move_tick (move_tick),
    .game_over (game_over),
    .restart   (restart),
    .dir       (dir),
    .run_en    (run_en),
    .dir_chg   (dir_chg),
    .drop      (drop)
  );

  // clock / reset
  initial lcd_pclk = 1'b0;
  always #5 lcd_pclk = ~lcd_pclk;

  function automatic logic [4:0] e(input logic [1:0] d, input logic r, input logic c,
                                   input logic dr);
    e = {d, r, c, dr};
  endfunction

  // driver tasks
  task automatic apply(input logic [3:0] u, input logic [3:0] b, input logic tk,
                       input logic go, input logic rs, input logic [4:0] exp_v,
                       input string nm);
    {uart_up, uart_down, uart_left, uart_right} = u;
    {btn_up, btn_down, btn_left, btn_right}     = b;
    move_tick = tk;
    game_over = go;
    restart   = rs;
    exp_q.push_back(exp_v);
    name_q.push_back(nm);
  endtask

  task automatic step(input logic [3:0] u, input logic [3:0] b, input logic tk,
                      input logic go, input logic rs, input logic [4:0] exp_v,
                      input string nm);
    @(negedge lcd_pclk);
    apply(u, b, tk, go, rs, exp_v, nm);
  endtask

  task automatic drain();
    @(negedge lcd_pclk);
    {uart_up, uart_down, uart_left, uart_right} = 4'b0;
    {btn_up, btn_down, btn_left, btn_right}     = 4'b0;
    move_tick = 1'b0;
    game_over = 1'b0;
    restart   = 1'b0;
    repeat (2) @(posedge lcd_pclk);
    #2;
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expected responses never checked", exp_q.size());
      exp_q.delete();
      name_q.delete();
    end
  endtask

  task automatic check_now(input logic [4:0] exp_v, input string nm);
    n_tests++;
    if ({dir, run_en, dir_chg, drop} !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got dir=%b run_en=%b dir_chg=%b drop=%b, expected %b",
               nm, dir, run_en, dir_chg, drop, exp_v);
    end
  endtask

  // scoreboard monitor
  always @(posedge lcd_pclk) begin
    #1;
    if (exp_q.size() > 0) begin
      logic [4:0] ev;
      string      nm;
      ev = exp_q.pop_front();
      nm = name_q.pop_front();
      n_tests++;
      if ({dir, run_en, dir_chg, drop} !== ev) begin
        n_fail++;
        $display("FAIL %s: got dir=%b run_en=%b dir_chg=%b drop=%b, expected %b",
                 nm, dir, run_en, dir_chg, drop, ev);
      end
    end
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    {uart_up, uart_down, uart_left, uart_right} = 4'b0;
    {btn_up, btn_down, btn_left, btn_right}     = 4'b0;
    move_tick = 1'b0;
    game_over = 1'b0;
    restart   = 1'b0;
    #7;
    check_now(e(2'b11, 0, 0, 0), "reset_vals");

    // first edge after release already grants
    @(negedge lcd_pclk);
    rst_n = 1'b1;
    apply(4'b1000, 4'b0000, 0, 0, 0, e(2'b00, 1, 1, 0), "idle_grant");
    step(4'b0000, 4'b0001, 0, 0, 0, e(2'b00, 1, 0, 0), "push_right");
    step(4'b0000, 4'b0000, 1, 0, 0, e(2'b11, 1, 1, 0), "pop_right");
    step(4'b0000, 4'b0010, 0, 0, 0, e(2'b11, 1, 0, 1), "reverse_drop");
    step(4'b0000, 4'b0000, 1, 0, 0, e(2'b11, 1, 0, 0), "tick_empty");
    step(4'b0100, 4'b1000, 0, 0, 0, e(2'b11, 1, 0, 1), "tie_u_wins");
    step(4'b0000, 4'b0000, 1, 0, 0, e(2'b01, 1, 1, 0), "pop_tie");
    step(4'b0000, 4'b0001, 0, 0, 0, e(2'b01, 1, 0, 0), "push_right2");
    step(4'b0000, 4'b0000, 1, 0, 0, e(2'b11, 1, 1, 0), "pop_right2");

    // two quick turns queued, third dropped while full
    step(4'b1000, 4'b0000, 0, 0, 0, e(2'b11, 1, 0, 0), "q_up");
    step(4'b0000, 4'b0010, 0, 0, 0, e(2'b11, 1, 0, 0), "q_left");
    step(4'b0100, 4'b0000, 0, 0, 0, e(2'b11, 1, 0, 1), "full_drop");
    step(4'b0000, 4'b0000, 1, 0, 0, e(2'b00, 1, 1, 0), "pop1");
    step(4'b0000, 4'b0000, 0, 0, 0, e(2'b00, 1, 0, 0), "between_ticks");
    step(4'b0000, 4'b0000, 1, 0, 0, e(2'b10, 1, 1, 0), "pop2");

    // full FIFO with simultaneous pop and push
    step(4'b1000, 4'b0000, 0, 0, 0, e(2'b10, 1, 0, 0), "fill_up");
    step(4'b0000, 4'b0001, 0, 0, 0, e(2'b10, 1, 0, 0), "fill_right");
    step(4'b0100, 4'b0000, 1, 0, 0, e(2'b00, 1, 1, 0), "push_pop_full");
    step(4'b0000, 4'b0000, 1, 0, 0, e(2'b11, 1, 1, 0), "pp_pop2");
    step(4'b0000, 4'b0000, 1, 0, 0, e(2'b01, 1, 1, 0), "pp_pop3");
    step(4'b0000, 4'b0000, 1, 0, 0, e(2'b01, 1, 0, 0), "fifo_drained");

    step(4'b0000, 4'b0100, 0, 0, 0, e(2'b01, 1, 0, 1), "same_dir_drop");
    step(4'b1100, 4'b0000, 0, 0, 0, e(2'b01, 1, 0, 0), "u_multi_invalid");
    step(4'b1100, 4'b0010, 0, 0, 0, e(2'b01, 1, 0, 0), "b_only_valid");

    // end of game
    step(4'b1000, 4'b0000, 0, 1, 0, e(2'b01, 0, 0, 0), "game_over");
    step(4'b0010, 4'b0000, 1, 0, 0, e(2'b01, 0, 0, 0), "halt_ignore");
    step(4'b0100, 4'b1000, 1, 0, 0, e(2'b01, 0, 0, 0), "halt_tie");
    step(4'b0000, 4'b0000, 0, 1, 1, e(2'b11, 0, 0, 0), "restart_over_go");
    step(4'b0000, 4'b0000, 1, 0, 0, e(2'b11, 0, 0, 0), "idle_tick");
    step(4'b0010, 4'b0000, 0, 0, 0, e(2'b10, 1, 1, 0), "regrant");
    step(4'b0000, 4'b0000, 1, 0, 0, e(2'b10, 1, 0, 0), "flushed");
    step(4'b1000, 4'b0100, 0, 0, 0, e(2'b10, 1, 0, 1), "tie_b_wins");
    step(4'b0000, 4'b0000, 1, 0, 0, e(2'b01, 1, 1, 0), "pop_b");
    step(4'b1000, 4'b0000, 0, 0, 1, e(2'b11, 0, 0, 0), "restart_req");

    // async reset with two turns pending
    step(4'b1000, 4'b0000, 0, 0, 0, e(2'b00, 1, 1, 0), "idle_grant2");
    step(4'b0000, 4'b0010, 0, 0, 0, e(2'b00, 1, 0, 0), "q2_left");
    step(4'b0100, 4'b0000, 0, 0, 0, e(2'b00, 1, 0, 0), "q2_down");
    drain();
    #1 rst_n = 1'b0;
    #1 check_now(e(2'b11, 0, 0, 0), "async_reset");
    @(negedge lcd_pclk);
    rst_n = 1'b1;
    apply(4'b0000, 4'b0000, 1, 0, 0, e(2'b11, 0, 0, 0), "post_reset_tick1");
    step(4'b0000, 4'b0000, 1, 0, 0, e(2'b11, 0, 0, 0), "post_reset_tick2");
    step(4'b0000, 4'b0001, 0, 0, 0, e(2'b11, 1, 1, 0), "post_reset_grant");
    step(4'b0000, 4'b0000, 1, 0, 0, e(2'b11, 1, 0, 0), "no_stale_entry");
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
